// File: rtl/uart_receiver.sv
// UART receive stage: recovers 8N1/8N2-style frames by sampling each line bit at its centre.
// Words are presented on a valid/ready interface, with frame_err and overrun reported as single-cycle pulses.
module uart_receiver #(
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_pin,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state, next_state;
  logic                    rx_meta, rx_s;
  logic [CW-1:0]           clk_cnt;
  logic [BW-1:0]           bit_idx;
  logic                    stop_idx;
  logic                    err;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    cnt_clr, data_smp, stop_smp, word_done, stop_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    data_smp   = 1'b0;
    stop_smp   = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) next_state = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          cnt_clr    = 1'b1;
          next_state = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == FULL_LAST) begin
          cnt_clr  = 1'b1;
          data_smp = 1'b1;
          if (bit_idx == BIT_LAST) next_state = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == FULL_LAST) begin
          cnt_clr  = 1'b1;
          stop_smp = 1'b1;
          // Leaving at mid-stop-bit lets a back-to-back start edge be seen in time
          if (stop_idx == STOP_LAST) begin
            next_state = IDLE;
            word_done  = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign stop_bad = err | ~rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      err       <= 1'b0;
      shift_reg <= '0;
    end else begin
      clk_cnt <= cnt_clr ? '0 : clk_cnt + CW'(1);
      if (state == START)  bit_idx <= '0;
      else if (data_smp)   bit_idx <= bit_idx + BW'(1);
      if (state == DATA) begin
        stop_idx <= 1'b0;
        err      <= 1'b0;
      end else if (stop_smp) begin
        stop_idx <= stop_idx + 1'b1;
        if (!rx_s) err <= 1'b1;
      end
      if (data_smp) shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (word_done) begin
        if (stop_bad) begin
          frame_err <= 1'b1;
        end else if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
